// File: rtl/lgm_pkg.sv
// Shared definitions for the logic_gate_mux operand protocol: gate codes, response
// status codes, driver FSM states and the operand mask helper.
package lgm_pkg;

    localparam logic [3:0] GateAnd  = 4'd2;
    localparam logic [3:0] GateOr   = 4'd3;
    localparam logic [3:0] GateNot  = 4'd4;
    localparam logic [3:0] GateNand = 4'd5;
    localparam logic [3:0] GateNor  = 4'd6;
    localparam logic [3:0] GateXor  = 4'd7;
    localparam logic [3:0] GateXnor = 4'd8;

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusTimeLim = 2'd1;
    localparam logic [1:0] StatusInpNum  = 2'd2;
    localparam logic [1:0] StatusWdog    = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StEnable,
        StSendOp,
        StGap,
        StFinal,
        StWaitRsp,
        StClrErr,
        StMuxRst,
        StRespond
    } lgm_state_e;

    // Bits set for the operands in use; nin is operand count minus one.
    function automatic logic [3:0] op_mask(input logic [1:0] nin);
        return 4'b1111 >> (2'd3 - nin);
    endfunction

endpackage

// File: rtl/logic_gate_mux_driver.sv
// Initiator for the logic_gate_mux operand protocol. Takes one host command, sequences
// en / operand acks / final ack into the mux, waits for the result or an error, recovers
// the mux and hands a result/status record back to the host.
module logic_gate_mux_driver
    import lgm_pkg::*;
#(
    parameter int unsigned OP_GAP       = 2,
    parameter int unsigned RESP_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_gate,
    input  logic [1:0] cmd_nin,
    input  logic [3:0] cmd_ops,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_out,
    output logic [1:0] rsp_status,
    output logic [1:0] rsp_inp_err,
    output logic       en,
    output logic [3:0] gate_type,
    output logic [1:0] no_of_inp,
    output logic       op1,
    output logic       op2,
    output logic       op3,
    output logic       op4,
    output logic       op_ack_in_pulse,
    output logic       final_inp_ack,
    output logic       err_clr,
    output logic       mux_reset,
    input  logic       out,
    input  logic       op_ack_out,
    input  logic       time_lim_err,
    input  logic [1:0] inp_num_err
);

    // Only meaningful when OP_GAP > 0; the zero-gap path never looks at it.
    localparam logic [3:0] GapLast   = 4'(OP_GAP - 1);
    localparam logic [5:0] WdogLimit = 6'(RESP_TIMEOUT);

    lgm_state_e state_q, state_d;
    logic [3:0] cmd_gate_q, cmd_gate_d;
    logic [1:0] cmd_nin_q, cmd_nin_d;
    logic [3:0] cmd_ops_q, cmd_ops_d;
    logic [1:0] op_idx_q, op_idx_d;
    logic       last_q, last_d;
    logic [3:0] gap_q, gap_d;
    logic [5:0] wdog_q, wdog_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_out_q, rsp_out_d;
    logic [1:0] rsp_status_q, rsp_status_d;
    logic [1:0] rsp_inp_err_q, rsp_inp_err_d;
    logic       en_q, en_d;
    logic [3:0] gate_type_q, gate_type_d;
    logic [1:0] no_of_inp_q, no_of_inp_d;
    logic [3:0] ops_q, ops_d;
    logic       op_ack_q, op_ack_d;
    logic       final_q, final_d;
    logic       err_clr_q, err_clr_d;
    logic       mux_reset_q, mux_reset_d;
    logic       hold;

    // Next-state, counters, response capture and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cmd_gate_d    = cmd_gate_q;
        cmd_nin_d     = cmd_nin_q;
        cmd_ops_d     = cmd_ops_q;
        op_idx_d      = op_idx_q;
        last_d        = last_q;
        gap_d         = gap_q;
        wdog_d        = wdog_q;
        rsp_out_d     = rsp_out_q;
        rsp_status_d  = rsp_status_q;
        rsp_inp_err_d = rsp_inp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_gate_d = cmd_gate;
                    cmd_nin_d  = cmd_nin;
                    cmd_ops_d  = cmd_ops & op_mask(cmd_nin);
                    op_idx_d   = 2'd0;
                    last_d     = 1'b0;
                    state_d    = StEnable;
                end
            end
            StEnable: state_d = StSendOp;
            StSendOp: begin
                last_d   = (op_idx_q == cmd_nin_q);
                op_idx_d = op_idx_q + 2'd1;
                gap_d    = 4'd0;
                if (OP_GAP == 0) begin
                    state_d = (op_idx_q == cmd_nin_q) ? StFinal : StSendOp;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q != 4'hF) gap_d = gap_q + 4'd1;
                if (gap_q >= GapLast) state_d = last_q ? StFinal : StSendOp;
            end
            StFinal: begin
                wdog_d  = 6'd0;
                state_d = StWaitRsp;
            end
            StWaitRsp: begin
                if (wdog_q != 6'h3F) wdog_d = wdog_q + 6'd1;
                if (time_lim_err) begin
                    rsp_status_d  = StatusTimeLim;
                    rsp_out_d     = 1'b0;
                    rsp_inp_err_d = inp_num_err;
                    state_d       = StClrErr;
                end else if (inp_num_err != 2'd0) begin
                    rsp_status_d  = StatusInpNum;
                    rsp_out_d     = 1'b0;
                    rsp_inp_err_d = inp_num_err;
                    state_d       = StClrErr;
                end else if (op_ack_out) begin
                    rsp_status_d  = StatusOk;
                    rsp_out_d     = out;
                    rsp_inp_err_d = 2'd0;
                    state_d       = StMuxRst;
                end else if (wdog_q == WdogLimit) begin
                    rsp_status_d  = StatusWdog;
                    rsp_out_d     = 1'b0;
                    rsp_inp_err_d = inp_num_err;
                    state_d       = StClrErr;
                end
            end
            StClrErr: state_d = StMuxRst;
            StMuxRst: state_d = StRespond;
            StRespond: begin
                if (rsp_valid_q && rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Mux-side outputs follow the state one cycle later; host-side handshake outputs
        // look at the next state so they never overlap a transfer.
        hold        = (state_q != StIdle) && (state_q != StRespond);
        en_d        = (state_q == StEnable);
        op_ack_d    = (state_q == StSendOp);
        final_d     = (state_q == StFinal);
        err_clr_d   = (state_q == StClrErr);
        mux_reset_d = (state_q != StMuxRst);
        gate_type_d = hold ? cmd_gate_q : 4'd0;
        no_of_inp_d = hold ? cmd_nin_q : 2'd0;
        ops_d       = hold ? cmd_ops_q : 4'd0;
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_q == StRespond) && !(rsp_valid_q && rsp_ready);
    end

    // State and output registers; mux_reset is held low while the driver is in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cmd_gate_q    <= 4'd0;
            cmd_nin_q     <= 2'd0;
            cmd_ops_q     <= 4'd0;
            op_idx_q      <= 2'd0;
            last_q        <= 1'b0;
            gap_q         <= 4'd0;
            wdog_q        <= 6'd0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_out_q     <= 1'b0;
            rsp_status_q  <= 2'd0;
            rsp_inp_err_q <= 2'd0;
            en_q          <= 1'b0;
            gate_type_q   <= 4'd0;
            no_of_inp_q   <= 2'd0;
            ops_q         <= 4'd0;
            op_ack_q      <= 1'b0;
            final_q       <= 1'b0;
            err_clr_q     <= 1'b0;
            mux_reset_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_gate_q    <= cmd_gate_d;
            cmd_nin_q     <= cmd_nin_d;
            cmd_ops_q     <= cmd_ops_d;
            op_idx_q      <= op_idx_d;
            last_q        <= last_d;
            gap_q         <= gap_d;
            wdog_q        <= wdog_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_out_q     <= rsp_out_d;
            rsp_status_q  <= rsp_status_d;
            rsp_inp_err_q <= rsp_inp_err_d;
            en_q          <= en_d;
            gate_type_q   <= gate_type_d;
            no_of_inp_q   <= no_of_inp_d;
            ops_q         <= ops_d;
            op_ack_q      <= op_ack_d;
            final_q       <= final_d;
            err_clr_q     <= err_clr_d;
            mux_reset_q   <= mux_reset_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_out         = rsp_out_q;
    assign rsp_status      = rsp_status_q;
    assign rsp_inp_err     = rsp_inp_err_q;
    assign en              = en_q;
    assign gate_type       = gate_type_q;
    assign no_of_inp       = no_of_inp_q;
    assign op1             = ops_q[0];
    assign op2             = ops_q[1];
    assign op3             = ops_q[2];
    assign op4             = ops_q[3];
    assign op_ack_in_pulse = op_ack_q;
    assign final_inp_ack   = final_q;
    assign err_clr         = err_clr_q;
    assign mux_reset       = mux_reset_q;

endmodule

// File: tb/tb_logic_gate_mux_driver.sv
// Bench for logic_gate_mux_driver: a behavioural mux responder plus a popcount-based
// reference for the expected host response and protocol timing.
module tb_logic_gate_mux_driver;
    import lgm_pkg::*;

    localparam int OP_GAP       = 2;
    localparam int RESP_TIMEOUT = 32;

    logic       clk, reset;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_gate;
    logic [1:0] cmd_nin;
    logic [3:0] cmd_ops;
    logic       rsp_valid, rsp_ready, rsp_out;
    logic [1:0] rsp_status, rsp_inp_err;
    logic       en;
    logic [3:0] gate_type;
    logic [1:0] no_of_inp;
    logic       op1, op2, op3, op4;
    logic       op_ack_in_pulse, final_inp_ack, err_clr, mux_reset;
    logic       out, op_ack_out, time_lim_err;
    logic [1:0] inp_num_err;

    logic_gate_mux_driver #(
        .OP_GAP      (OP_GAP),
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_gate       (cmd_gate),
        .cmd_nin        (cmd_nin),
        .cmd_ops        (cmd_ops),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_out        (rsp_out),
        .rsp_status     (rsp_status),
        .rsp_inp_err    (rsp_inp_err),
        .en             (en),
        .gate_type      (gate_type),
        .no_of_inp      (no_of_inp),
        .op1            (op1),
        .op2            (op2),
        .op3            (op3),
        .op4            (op4),
        .op_ack_in_pulse(op_ack_in_pulse),
        .final_inp_ack  (final_inp_ack),
        .err_clr        (err_clr),
        .mux_reset      (mux_reset),
        .out            (out),
        .op_ack_out     (op_ack_out),
        .time_lim_err   (time_lim_err),
        .inp_num_err    (inp_num_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- behavioural mux responder ----------------
    bit         stub;
    logic       m_busy, m_fin;
    logic [4:0] m_cnt;
    logic [3:0] m_gate, m_ops;
    logic [1:0] m_nin;

    function automatic logic mux_eval(input logic [3:0] g, input logic [1:0] n,
                                      input logic [3:0] o);
        logic [3:0] m, a;
        m = op_mask(n);
        a = o & m;
        case (g)
            GateAnd:  return &(o | ~m);
            GateOr:   return |a;
            GateNot:  return ~o[0];
            GateNand: return ~&(o | ~m);
            GateNor:  return ~|a;
            GateXor:  return ^a;
            GateXnor: return ~^a;
            default:  return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge mux_reset) begin
        if (!mux_reset) begin
            m_busy <= 0; m_fin <= 0; m_cnt <= 0; m_gate <= 0; m_nin <= 0; m_ops <= 0;
            out <= 0; op_ack_out <= 0; time_lim_err <= 0; inp_num_err <= 0;
        end else begin
            m_fin <= 0;
            if (en) begin
                m_busy <= 1; m_cnt <= 0; m_gate <= gate_type; m_nin <= no_of_inp;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 5'd1;
                if (op_ack_in_pulse) m_ops <= {op4, op3, op2, op1};
                if (final_inp_ack && !stub) m_fin <= 1;
                if (m_fin) begin
                    if (m_gate >= 4'd2 && m_gate <= 4'd8) begin
                        m_busy <= 0;
                        if (m_gate == GateNot && m_nin != 2'd0) inp_num_err <= 2'b01;
                        else begin
                            op_ack_out <= 1;
                            out        <= mux_eval(m_gate, m_nin, m_ops);
                        end
                    end
                end else if (m_cnt == 5'd15 && !stub) begin
                    time_lim_err <= 1;
                    m_busy       <= 0;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int en_cnt, en_at, pulse_cnt, p1_at, p2_at, fin_cnt, fin_at;
    int mrst_cnt, mrst_at, eclr_cnt, eclr_at, rsp_at, crdy_bad, pin_bad;
    bit busy;
    logic [3:0] exp_pins;

    always @(negedge clk) begin
        if (reset) begin
            if (en) begin en_cnt++; en_at = cyc; end
            if (op_ack_in_pulse) begin
                pulse_cnt++;
                if (pulse_cnt == 1) p1_at = cyc;
                if (pulse_cnt == 2) p2_at = cyc;
                if ({op4, op3, op2, op1} !== exp_pins) pin_bad++;
            end
            if (final_inp_ack) begin fin_cnt++; fin_at = cyc; end
            if (!mux_reset) begin mrst_cnt++; mrst_at = cyc; end
            if (err_clr) begin eclr_cnt++; eclr_at = cyc; end
            if (rsp_valid && rsp_at < 0) rsp_at = cyc;
            if (busy && cmd_ready) crdy_bad++;
        end
    end

    // ---------------- reference model ----------------
    task automatic ref_model(input logic [3:0] g, input logic [1:0] n, input logic [3:0] o,
                             input bit stub_m, output logic [1:0] st, output logic r,
                             output logic [1:0] ie);
        int k, ones;
        k    = int'(n) + 1;
        ones = 0;
        for (int i = 0; i < k; i++) ones += int'(o[i]);
        st = 2'd0; r = 1'b0; ie = 2'd0;
        if (stub_m) st = 2'd3;
        else if (g < 4'd2 || g > 4'd8) st = 2'd1;
        else if (g == GateNot && n != 2'd0) begin st = 2'd2; ie = 2'd1; end
        else begin
            case (g)
                GateAnd:  r = (ones == k);
                GateOr:   r = (ones > 0);
                GateNot:  r = (o[0] == 1'b0);
                GateNand: r = (ones != k);
                GateNor:  r = (ones == 0);
                GateXor:  r = (ones % 2 == 1);
                default:  r = (ones % 2 == 0);
            endcase
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0; en_at = -1; pulse_cnt = 0; p1_at = -1; p2_at = -1; fin_cnt = 0;
        fin_at = -1; mrst_cnt = 0; mrst_at = -1; eclr_cnt = 0; eclr_at = -1; rsp_at = -1;
        crdy_bad = 0; pin_bad = 0;
    endtask

    task automatic run_txn(input string name, input logic [3:0] g, input logic [1:0] n,
                           input logic [3:0] o, input int hold, input bit stub_m);
        logic [1:0] es, ei;
        logic       eo;
        logic [4:0] snap;
        int acc, f, w, unstable;
        ref_model(g, n, o, stub_m, es, eo, ei);
        @(negedge clk);
        stub = stub_m;
        clear_mon();
        for (int i = 0; i < 4; i++) exp_pins[i] = (i <= int'(n)) ? o[i] : 1'b0;
        cmd_valid = 1; cmd_gate = g; cmd_nin = n; cmd_ops = o;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        check_eq({name, " cmd_ready"}, cmd_ready, 1);
        acc = cyc + 1;
        @(posedge clk);
        busy = 1;
        @(negedge clk);
        cmd_valid = 0;
        cmd_gate = 4'($urandom); cmd_nin = 2'($urandom); cmd_ops = 4'($urandom);
        w = 0;
        while (!rsp_valid && w < 200) begin @(negedge clk); w++; end
        check_eq({name, " rsp_valid"}, rsp_valid, 1);
        snap = {rsp_valid, rsp_out, rsp_status, rsp_inp_err[0]};
        unstable = 0;
        repeat (hold) begin
            @(negedge clk);
            if ({rsp_valid, rsp_out, rsp_status, rsp_inp_err[0]} !== snap) unstable++;
        end
        check_eq({name, " rsp stable"}, unstable, 0);
        check_eq({name, " rsp_status"}, rsp_status, es);
        check_eq({name, " rsp_out"}, rsp_out, eo);
        check_eq({name, " rsp_inp_err"}, rsp_inp_err, ei);
        rsp_ready = 1;
        @(posedge clk);
        busy = 0;
        @(negedge clk);
        rsp_ready = 0;
        check_eq({name, " rsp_valid drop"}, rsp_valid, 0);
        check_eq({name, " cmd_ready back"}, cmd_ready, 1);
        f = 2 + (int'(n) + 1) * (OP_GAP + 1);
        check_eq({name, " en count"}, en_cnt, 1);
        check_eq({name, " en time"}, en_at - acc, 1);
        check_eq({name, " pulse count"}, pulse_cnt, int'(n) + 1);
        check_eq({name, " pulse1 time"}, p1_at - acc, 2);
        if (n != 2'd0) check_eq({name, " pulse2 time"}, p2_at - acc, 2 + OP_GAP + 1);
        check_eq({name, " final count"}, fin_cnt, 1);
        check_eq({name, " final time"}, fin_at - acc, f);
        check_eq({name, " mux_reset count"}, mrst_cnt, 1);
        check_eq({name, " err_clr count"}, eclr_cnt, (es != 2'd0) ? 1 : 0);
        check_eq({name, " op pins"}, pin_bad, 0);
        check_eq({name, " cmd_ready busy"}, crdy_bad, 0);
        if (es == 2'd0) begin
            check_eq({name, " mux_reset time"}, mrst_at - acc, f + 4);
            check_eq({name, " rsp time"}, rsp_at - acc, f + 5);
        end else begin
            check_eq({name, " clr then rst"}, mrst_at - eclr_at, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    int w;
    logic [3:0] rg;

    initial begin
        reset = 0; cmd_valid = 0; cmd_gate = 0; cmd_nin = 0; cmd_ops = 0; rsp_ready = 0;
        stub = 0; busy = 0; exp_pins = 0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_eq("reset cmd_ready", cmd_ready, 1);
        check_eq("reset mux_reset", mux_reset, 0);
        check_eq("reset rsp_valid", rsp_valid, 0);
        check_eq("reset gate_type", gate_type, 0);
        check_eq("reset en", en, 0);
        reset = 1;
        @(negedge clk);
        check_eq("release mux_reset", mux_reset, 1);

        run_txn("and_0011", GateAnd, 2'd1, 4'b0011, 0, 0);
        run_txn("xor_0111", GateXor, 2'd3, 4'b0111, 1, 0);
        run_txn("nor_000", GateNor, 2'd2, 4'b1000, 0, 0);
        run_txn("not_nin2", GateNot, 2'd2, 4'b0101, 2, 0);
        run_txn("and_after_err", GateAnd, 2'd2, 4'b0111, 0, 0);
        run_txn("gate_f", 4'hF, 2'd1, 4'b0011, 0, 0);
        run_txn("stub_wdog", GateOr, 2'd0, 4'b0001, 5, 1);
        run_txn("or_after_wdog", GateOr, 2'd0, 4'b0001, 0, 0);

        // Reset asserted while the driver is idling between operands.
        @(negedge clk);
        cmd_valid = 1; cmd_gate = GateAnd; cmd_nin = 2'd3; cmd_ops = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        w = 0;
        while (!op_ack_in_pulse && w < 20) begin @(negedge clk); w++; end
        check_eq("rst_mid pulse seen", op_ack_in_pulse, 1);
        @(negedge clk);
        reset = 0;
        #1;
        check_eq("rst_mid cmd_ready", cmd_ready, 1);
        check_eq("rst_mid mux_reset", mux_reset, 0);
        check_eq("rst_mid gate_type", gate_type, 0);
        check_eq("rst_mid ops", {op4, op3, op2, op1, no_of_inp}, 0);
        check_eq("rst_mid pulses", {en, op_ack_in_pulse, final_inp_ack, err_clr, rsp_valid}, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_eq("rst_mid release ready", cmd_ready, 1);
        check_eq("rst_mid release mux_reset", mux_reset, 1);
        run_txn("after_rst", GateNand, 2'd1, 4'b0011, 0, 0);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 9))
                0:       rg = 4'd0;
                1:       rg = 4'hF;
                default: rg = 4'($urandom_range(2, 8));
            endcase
            run_txn($sformatf("rnd%0d", t), rg, 2'($urandom), 4'($urandom),
                    $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
